// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the stall controller and the pipeline:
// hazard/branch/memory status in, per-stage freeze/flush controls out.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             hazard_Detected;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_cnt;
    logic             freeze_IF;
    logic             freeze_ID;
    logic             flush_IF;
    logic             bubble_ID;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hazard_Detected,
        output branch_taken,
        output mem_req,
        output mem_ready,
        output clr_cnt,
        input  freeze_IF,
        input  freeze_ID,
        input  flush_IF,
        input  bubble_ID,
        input  freeze_back,
        input  mem_timeout,
        input  stall_cnt,
        input  flush_cnt
    );

    modport slave (
        input  hazard_Detected,
        input  branch_taken,
        input  mem_req,
        input  mem_ready,
        input  clr_cnt,
        output freeze_IF,
        output freeze_ID,
        output flush_IF,
        output bubble_ID,
        output freeze_back,
        output mem_timeout,
        output stall_cnt,
        output flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits,
// branch flushes, hazard bubbles, wait timeout and perf counters.
module pipeline_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TMO_W       = 7
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_stall_controller_if.slave   bus
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    state_t           state;
    logic [TMO_W-1:0] wcnt;
    logic [TMO_W-1:0] wcnt_nxt;
    logic             tmo;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic mem_stall;
    logic br_sel;
    logic hz_sel;
    logic f_if;
    logic f_id;
    logic fl_if;
    logic bub;
    logic f_bk;

    // Priority is flattened into one-hot selects: memory > branch > hazard.
    assign mem_stall = ~bus.mem_ready &
                       ((state == RUN & bus.mem_req) | state == MEM_WAIT);
    assign br_sel    = ~mem_stall & bus.branch_taken;
    assign hz_sel    = ~mem_stall & ~bus.branch_taken &
                       bus.hazard_Detected;

    always_comb begin
        f_if  = 1'b0;
        f_id  = 1'b0;
        fl_if = 1'b0;
        bub   = 1'b0;
        f_bk  = 1'b0;
        if (rst) begin
            unique case (1'b1)
                mem_stall: begin
                    f_if = 1'b1;
                    f_id = 1'b1;
                    f_bk = 1'b1;
                end
                br_sel: begin
                    fl_if = 1'b1;
                    bub   = 1'b1;
                end
                hz_sel: begin
                    f_if = 1'b1;
                    f_id = 1'b1;
                    bub  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wcnt_nxt = (wcnt == '1) ? wcnt : wcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RUN;
            wcnt    <= '0;
            tmo     <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        state <= MEM_WAIT;
                        wcnt  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= RUN;
                    end else begin
                        wcnt <= wcnt_nxt;
                        if (wcnt_nxt >= TMO_LIM)
                            tmo <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            if (bus.clr_cnt)
                stall_q <= '0;
            else if (f_if && stall_q != '1)
                stall_q <= stall_q + 1'b1;

            if (bus.clr_cnt)
                flush_q <= '0;
            else if (fl_if && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.freeze_IF   = f_if;
    assign bus.freeze_ID   = f_id;
    assign bus.flush_IF    = fl_if;
    assign bus.bubble_ID   = bub;
    assign bus.freeze_back = f_bk;
    assign bus.mem_timeout = tmo;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller, built with
// CNT_W=4 and MEM_TIMEOUT=8 so saturation and timeout are reachable.
module tb_pipeline_stall_controller;

    localparam int CW = 4;

    typedef struct {
        logic          rst;
        logic          hz;
        logic          br;
        logic          req;
        logic          rdy;
        logic          clr;
        logic [4:0]    outs;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
        logic          tmo;
    } vec_t;

    // outs = {freeze_IF, freeze_ID, flush_IF, bubble_ID, freeze_back}
    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_HAZ  = 5'b11010;
    localparam logic [4:0] O_BR   = 5'b00110;
    localparam logic [4:0] O_MEM  = 5'b11001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

    pipeline_stall_controller #(
        .CNT_W      (CW),
        .MEM_TIMEOUT(8),
        .TMO_W      (7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input vec_t v, input string tag);
        logic [4:0] got;
        @(negedge clk);
        rst                 = v.rst;
        bus.hazard_Detected = v.hz;
        bus.branch_taken    = v.br;
        bus.mem_req         = v.req;
        bus.mem_ready       = v.rdy;
        bus.clr_cnt         = v.clr;
        #1;
        got = {bus.freeze_IF, bus.freeze_ID, bus.flush_IF,
               bus.bubble_ID, bus.freeze_back};
        n_cmp++;
        if (got !== v.outs) begin
            n_bad++;
            $display("FAIL %s ctl: got %b want %b", tag, got, v.outs);
        end
        if (bus.flush_IF && bus.freeze_ID) begin
            n_bad++;
            $display("FAIL %s inv: flush_IF with freeze_ID", tag);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.stall_cnt !== v.stall || bus.flush_cnt !== v.flush ||
            bus.mem_timeout !== v.tmo) begin
            n_bad++;
            $display("FAIL %s cnt: got s=%0d f=%0d t=%b want s=%0d f=%0d t=%b",
                     tag, bus.stall_cnt, bus.flush_cnt, bus.mem_timeout,
                     v.stall, v.flush, v.tmo);
        end
    endtask

    vec_t tbl[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst                 = 1'b0;
        bus.hazard_Detected = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
        bus.clr_cnt         = 1'b0;

        //             rst hz br rq rd cl outs    st fl tmo
        tbl.push_back('{0, 0, 0, 0, 0, 0, O_NONE, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, O_NONE, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, O_HAZ,  1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, O_HAZ,  2, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, O_BR,   2, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, O_NONE, 2, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, O_NONE, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  1, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  2, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  3, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  4, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 1, 0, O_BR,   4, 1, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 0, O_NONE, 4, 1, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 0, O_HAZ,  5, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, O_NONE, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 0, O_MEM,  1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 0, O_HAZ,  2, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  3, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 0, O_MEM,  4, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 0, O_NONE, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, O_NONE, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, O_BR,   0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, O_NONE, 0, 0, 0});

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        // Long wait: timeout sets once the wait counter reaches 8.
        for (int i = 1; i <= 10; i++) begin
            vec_t v;
            v = '{1, 0, 0, 1, 0, 0, O_MEM, CW'(i), 0, (i >= 9)};
            apply(v, $sformatf("tmo%0d", i));
        end
        apply('{1, 0, 0, 1, 1, 0, O_NONE, 10, 0, 1}, "tmo_rel");
        apply('{1, 0, 0, 0, 0, 0, O_NONE, 10, 0, 1}, "tmo_idle");
        apply('{1, 0, 0, 0, 0, 1, O_NONE, 0, 0, 1}, "tmo_clr");

        // Stall counter saturation, then clear beating the increment.
        for (int i = 1; i <= 20; i++) begin
            vec_t v;
            v = '{1, 1, 0, 0, 0, 0, O_HAZ,
                  CW'((i > 15) ? 15 : i), 0, 1};
            apply(v, $sformatf("sat%0d", i));
        end
        apply('{1, 1, 0, 0, 0, 1, O_HAZ,  0, 0, 1}, "sat_clr");
        apply('{1, 1, 0, 0, 0, 0, O_HAZ,  1, 0, 1}, "sat_post");
        apply('{0, 1, 0, 0, 0, 0, O_NONE, 0, 0, 0}, "final_rst");
        apply('{1, 0, 0, 0, 0, 0, O_NONE, 0, 0, 0}, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
